// File: rtl/seq_cla_pkg.sv
// Shared definitions for the sequential carry-lookahead ALU.
//   OP_*    : 2-bit operation codes presented on the op port
//   state_t : control FSM states
package seq_cla_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_cla_alu_cla_group.sv
// Combinational GROUP-bit carry-lookahead slice.
//   a, b  in  GROUP  slice operands
//   ci    in  1      carry into the slice
//   s     out GROUP  slice sum
//   co    out 1      carry out of the slice
//   cmsb  out 1      carry into the slice MSB (for signed overflow)
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             cmsb
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is the flat sum-of-products c[i] = g[j] & p[j+1..i-1]
    // over all j, plus ci & p[0..i-1]; no carry depends on another carry.
    always_comb begin
        logic t;
        t   = 1'b0;
        w_c = '0;
        w_c[0] = ci;
        for (int i = 1; i <= GROUP; i++) begin
            t = ci;
            for (int j = 0; j < i; j++) t = t & w_p[j];
            w_c[i] = t;
            for (int j = 0; j < i; j++) begin
                t = w_g[j];
                for (int k = j + 1; k < i; k++) t = t & w_p[k];
                w_c[i] = w_c[i] | t;
            end
        end
    end

    assign s    = w_p ^ w_c[GROUP-1:0];
    assign co   = w_c[GROUP];
    assign cmsb = w_c[GROUP-1];

endmodule

// File: rtl/seq_cla_alu.sv
// Sequential WIDTH-bit add/subtract/accumulate unit. One GROUP-bit CLA slice
// is evaluated per clock, the inter-slice carry living in a register.
//   CLOCK_50            in   clock, rising edge
//   reset               in   synchronous, active-high
//   in_valid/in_ready   request handshake (op, a, b, cin)
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   acc                 out  accumulator register
module seq_cla_alu
    import seq_cla_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam int NG = (GROUP < 1) ? 1 : WIDTH / GROUP;
    localparam int IW = (NG > 1) ? $clog2(NG) : 1;

    if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_params
        $fatal(1, "seq_cla_alu: WIDTH must be a non-zero multiple of GROUP");
    end

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_work;
    logic             r_cout;
    logic             r_ovf;
    logic [WIDTH-1:0] r_acc;
    logic             r_out_valid;

    logic [GROUP-1:0] w_a_sl;
    logic [GROUP-1:0] w_b_sl;
    logic [GROUP-1:0] w_s;
    logic             w_co;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_next_work;
    logic             w_last;

    assign w_a_sl = GROUP'(r_a >> (int'(r_idx) * GROUP));
    assign w_b_sl = GROUP'(r_b >> (int'(r_idx) * GROUP));

    cla_group #(.GROUP(GROUP)) u_cla (
        .a    (w_a_sl),
        .b    (w_b_sl),
        .ci   (r_c),
        .s    (w_s),
        .co   (w_co),
        .cmsb (w_cmsb)
    );

    // Working sum is cleared on accept, so OR-ing the slice in place is exact.
    assign w_next_work = r_work | (WIDTH'(w_s) << (int'(r_idx) * GROUP));
    assign w_last      = (r_idx == IW'(NG - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= 1'b0;
            r_idx       <= '0;
            r_work      <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op   <= op;
                        r_work <= '0;
                        r_idx  <= '0;
                        r_cout <= 1'b0;
                        r_ovf  <= 1'b0;
                        case (op)
                            OP_ADD: begin r_a <= a;     r_b <= b;  r_c <= cin;  end
                            OP_SUB: begin r_a <= a;     r_b <= ~b; r_c <= 1'b1; end
                            OP_ACC: begin r_a <= r_acc; r_b <= a;  r_c <= cin;  end
                            default: begin r_a <= '0;   r_b <= '0; r_c <= 1'b0; end
                        endcase
                        if (op == OP_CLR) begin
                            r_acc   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_work <= w_next_work;
                    r_c    <= w_co;
                    r_idx  <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout      <= w_co;
                        r_ovf       <= w_cmsb ^ w_co;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                        if (r_op == OP_ACC) r_acc <= w_next_work;
                    end
                end
                S_DONE: begin
                    // CLR arrives here with out_valid low; raise it one edge
                    // later so the result is presented one edge after accept.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign out_valid = r_out_valid;
    assign sum       = r_work;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign acc       = r_acc;

endmodule

// File: tb/tb_seq_cla_alu.sv
module tb_seq_cla_alu;
    import seq_cla_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit / 4-bit-group unit
    logic       iv = 1'b0, ordy = 1'b0, ci = 1'b0;
    logic       ir, ov, co, of;
    logic [1:0] op = OP_ADD;
    logic [7:0] a = '0, b = '0, s, ac;

    // 16-bit unit (NG=4)
    logic        iv16 = 1'b0, or16 = 1'b0;
    logic        ir16, ov16, co16, of16;
    logic [15:0] a16 = '0, b16 = '0, s16, ac16;

    // 4-bit unit (NG=1)
    logic       iv4 = 1'b0, or4 = 1'b0;
    logic       ir4, ov4, co4, of4;
    logic [3:0] a4 = '0, b4 = '0, s4, ac4;

    seq_cla_alu #(.WIDTH(8), .GROUP(4)) dut (
        .CLOCK_50(clk), .reset(rst), .in_valid(iv), .in_ready(ir), .op(op),
        .a(a), .b(b), .cin(ci), .out_valid(ov), .out_ready(ordy),
        .sum(s), .cout(co), .ovf(of), .acc(ac)
    );

    seq_cla_alu #(.WIDTH(16), .GROUP(4)) dut16 (
        .CLOCK_50(clk), .reset(rst), .in_valid(iv16), .in_ready(ir16), .op(OP_ADD),
        .a(a16), .b(b16), .cin(1'b0), .out_valid(ov16), .out_ready(or16),
        .sum(s16), .cout(co16), .ovf(of16), .acc(ac16)
    );

    seq_cla_alu #(.WIDTH(4), .GROUP(4)) dut4 (
        .CLOCK_50(clk), .reset(rst), .in_valid(iv4), .in_ready(ir4), .op(OP_ADD),
        .a(a4), .b(b4), .cin(1'b0), .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4), .ovf(of4), .acc(ac4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic [7:0] acc;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_acc = '0;

    // Reference model: plain integer add on the effective operands.
    function automatic void push_exp(logic [1:0] o, logic [7:0] x, logic [7:0] y, logic c);
        exp_t       e;
        logic [7:0] A, B;
        logic       cc;
        logic [8:0] r;
        case (o)
            OP_ADD:  begin A = x;     B = y;  cc = c;    end
            OP_SUB:  begin A = x;     B = ~y; cc = 1'b1; end
            OP_ACC:  begin A = m_acc; B = x;  cc = c;    end
            default: begin A = '0;    B = '0; cc = 1'b0; end
        endcase
        r = {1'b0, A} + {1'b0, B} + 9'(cc);
        if (o == OP_CLR) begin
            e.sum = '0; e.cout = 1'b0; e.ovf = 1'b0; e.lat = 1;
            m_acc = '0;
        end else begin
            e.sum  = r[7:0];
            e.cout = r[8];
            e.ovf  = (A[7] == B[7]) && (r[7] != A[7]);
            e.lat  = 2;
            if (o == OP_ACC) m_acc = r[7:0];
        end
        e.acc = m_acc;
        sb.push_back(e);
    endfunction

    // Drive one request into the 8-bit unit; lat = edges from accept to out_valid.
    task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic c, output int lat);
        int w = 0;
        while (!ir && w < 50) begin @(posedge clk); #1; w++; end
        push_exp(o, x, y, c);
        op = o; a = x; b = y; ci = c; iv = 1'b1;
        @(posedge clk); #1;
        iv  = 1'b0;
        lat = 0;
        while (!ov && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic retire();
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ov !== 1'b0 || ir !== 1'b0 || s !== 8'h00 || ac !== 8'h00 || co !== 1'b0 || of !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b ir=%b sum=%h acc=%h cout=%b ovf=%b, want 0 0 00 00 0 0",
                     ov, ir, s, ac, co, of);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (ir !== 1'b1 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ir=%b ov=%b, want ir=1 ov=0", ir, ov);
        end
    endtask

    task automatic test_add_sub();
        logic [1:0] ops[6];
        logic [7:0] xs[6];
        logic [7:0] ys[6];
        logic       cs[6];
        int         lat;
        exp_t       e;
        ops = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
        xs  = '{8'h7F,  8'hFF,  8'h12,  8'h05,  8'h80,  8'h33};
        ys  = '{8'h01,  8'h00,  8'h34,  8'h07,  8'h01,  8'h33};
        cs  = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], xs[i], ys[i], cs[i], lat);
            e = sb.pop_front();
            n_tests++;
            if (s !== e.sum || co !== e.cout || of !== e.ovf || ac !== e.acc || lat !== e.lat) begin
                n_fail++;
                $display("FAIL add_sub[%0d]: got sum=%h cout=%b ovf=%b acc=%h lat=%0d, want sum=%h cout=%b ovf=%b acc=%h lat=%0d",
                         i, s, co, of, ac, lat, e.sum, e.cout, e.ovf, e.acc, e.lat);
            end
            retire();
        end
    endtask

    task automatic test_acc();
        logic [1:0] ops[3];
        logic [7:0] xs[3];
        int         lat;
        exp_t       e;
        ops = '{OP_CLR, OP_ACC, OP_ACC};
        xs  = '{8'h00,  8'h10,  8'hF5};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], xs[i], 8'hAA, 1'b0, lat);
            e = sb.pop_front();
            n_tests++;
            if (s !== e.sum || co !== e.cout || of !== e.ovf || ac !== e.acc || lat !== e.lat) begin
                n_fail++;
                $display("FAIL acc[%0d]: got sum=%h cout=%b ovf=%b acc=%h lat=%0d, want sum=%h cout=%b ovf=%b acc=%h lat=%0d",
                         i, s, co, of, ac, lat, e.sum, e.cout, e.ovf, e.acc, e.lat);
            end
            retire();
        end
    endtask

    task automatic test_back_pressure();
        int   lat;
        exp_t e;
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0, lat);
        e = sb.pop_front();
        n_tests++;
        if (s !== e.sum || co !== e.cout || of !== e.ovf || ac !== e.acc || lat !== e.lat) begin
            n_fail++;
            $display("FAIL bp_result: got sum=%h cout=%b ovf=%b acc=%h lat=%0d, want sum=%h cout=%b ovf=%b acc=%h lat=%0d",
                     s, co, of, ac, lat, e.sum, e.cout, e.ovf, e.acc, e.lat);
        end
        op = OP_ACC; a = 8'h11; b = 8'h22; iv = 1'b1; ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (ov !== 1'b1 || s !== e.sum || ac !== e.acc || ir !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ov=%b sum=%h acc=%h ir=%b, want ov=1 sum=%h acc=%h ir=0",
                         i, ov, s, ac, ir, e.sum, e.acc);
            end
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        n_tests++;
        if (ov !== 1'b0 || ir !== 1'b1 || s !== e.sum || ac !== e.acc) begin
            n_fail++;
            $display("FAIL bp_release: got ov=%b ir=%b sum=%h acc=%h, want ov=0 ir=1 sum=%h acc=%h",
                     ov, ir, s, ac, e.sum, e.acc);
        end
        iv = 1'b0;
    endtask

    task automatic test_wide();
        int lat;
        a16 = 16'hFFFF; b16 = 16'h0001; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat  = 0;
        while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if (s16 !== 16'h0000 || co16 !== 1'b1 || of16 !== 1'b0 || ac16 !== 16'h0000 || lat !== 4) begin
            n_fail++;
            $display("FAIL wide16: got sum=%h cout=%b ovf=%b acc=%h lat=%0d, want sum=0000 cout=1 ovf=0 acc=0000 lat=4",
                     s16, co16, of16, ac16, lat);
        end
        or16 = 1'b1; @(posedge clk); #1; or16 = 1'b0;

        a4 = 4'h7; b4 = 4'h1; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 50) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if (s4 !== 4'h8 || co4 !== 1'b0 || of4 !== 1'b1 || lat !== 1) begin
            n_fail++;
            $display("FAIL single_group: got sum=%h cout=%b ovf=%b lat=%0d, want sum=8 cout=0 ovf=1 lat=1",
                     s4, co4, of4, lat);
        end
        or4 = 1'b1; @(posedge clk); #1; or4 = 1'b0;
    endtask

    task automatic test_reset_busy();
        int   lat;
        exp_t e;
        issue(OP_CLR, 8'h00, 8'h00, 1'b0, lat); e = sb.pop_front(); retire();
        issue(OP_ACC, 8'h10, 8'h00, 1'b0, lat); e = sb.pop_front();
        n_tests++;
        if (ac !== 8'h10 || s !== e.sum || lat !== e.lat) begin
            n_fail++;
            $display("FAIL rb_setup: got acc=%h sum=%h lat=%0d, want acc=10 sum=%h lat=%0d", ac, s, lat, e.sum, e.lat);
        end
        retire();
        op = OP_ACC; a = 8'h33; ci = 1'b0; iv = 1'b1;
        @(posedge clk); #1;
        iv  = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (ov !== 1'b0 || ac !== 8'h00 || s !== 8'h00 || ir !== 1'b0) begin
            n_fail++;
            $display("FAIL rb_reset: got ov=%b acc=%h sum=%h ir=%b, want ov=0 acc=00 sum=00 ir=0", ov, ac, s, ir);
        end
        m_acc = '0;
        rst   = 1'b0;
        #1;
        n_tests++;
        if (ir !== 1'b1) begin
            n_fail++;
            $display("FAIL rb_ready: got ir=%b, want 1", ir);
        end
        @(posedge clk); #1;
        n_tests++;
        if (ov !== 1'b0 || ac !== 8'h00) begin
            n_fail++;
            $display("FAIL rb_after: got ov=%b acc=%h, want ov=0 acc=00", ov, ac);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_acc();
        test_back_pressure();
        test_wide();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
